hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Parametrised successor to the fixed 5-stage forwarding and hazard-detect pair in the CPU pipeline.
- Keeps an internal scoreboard of in-flight destination registers across a configurable number of post-decode stages.
- Generates forward selects for the EX-stage operands and load-use/long-latency stalls for the ID stage.
- Supports a configurable source count and load latency; handles branch flush.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, source operands per instruction.
- DEPTH, 3, tracked stages from EX (age 1) to WB (age DEPTH); must be ≥ 2+LOAD_LAT.
- LOAD_LAT, 1, extra cycles after MEM before load data is forwardable.
- SEL_W, $clog2(DEPTH+1), forward-select width.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_src_i  in  NUM_SRC*REG_AW  ID source register addresses, packed with src0 in the LSBs.
- id_src_used_i  in  NUM_SRC  per-source "operand actually read".
- id_rd_i  in  REG_AW  ID destination register (post RegDst).
- id_regwrite_i  in  1  ID instruction writes a register.
- id_memread_i  in  1  ID instruction is a load.
- flush_i  in  1  squash the ID instruction (taken branch/jump).
- stall_o  out  1  hold PC and IF/ID; insert a bubble into EX.
- pc_write_o  out  1  equals ~stall_o.
- if_id_write_o  out  1  equals ~stall_o.
- fwd_sel_o  out  NUM_SRC*SEL_W  per EX source: 0 = register file, k = forward from age-k stage (2..DEPTH).

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-low.
- Reset values: all scoreboard entries invalid, EX-source copies 0, stall_o=0, pc_write_o=1, if_id_write_o=1, fwd_sel_o all 0.
- Scoreboard entry fields: valid, rd, is_load, 1 per age 1..DEPTH. Every clock edge the scoreboard shifts age a → a+1; the entry at age DEPTH retires, since the register file is write-through.
- Issue to age 1:
  - If id_valid_i & ~stall_o & ~flush_i: {valid=id_regwrite_i && id_rd_i!=0, rd, is_load=id_memread_i}; the id_src_i/id_src_used_i copies are registered into the EX-source copies.
  - Otherwise a bubble issues: valid=0, EX-source copies' used bits cleared.
- Ready stage: ALU producer = 2; load producer = 2+LOAD_LAT.
- Stall (combinational from ID inputs + registered state):
  - Asserted if any used ID source s≠0 matches a valid entry of age a with a+1 < ready_stage, and no younger valid entry with the same rd exists.
  - Gated by id_valid_i & ~flush_i.
- Flush: flush_i=1 forces stall_o=0 and a bubble issue. Flush dominates stall.
- Forward select (combinational from registered EX-source copies):
  - For each used EX source ≠0, take the youngest (smallest age ≥2) valid matching entry.
  - sel = that age if age ≥ ready_stage, else 0. The "else 0" case is unreachable by construction and is flagged by an assertion.
  - No match, src=0, or unused → 0.
- Register 0 never matches, never stalls, never forwards.
- Latency:
  - stall_o responds in the same cycle as the ID inputs.
  - fwd_sel_o applies to the instruction issued at the previous edge.
  - A 1-cycle load-use bubble at defaults; LOAD_LAT=N gives N bubbles.
- Back-to-back writers of the same rd: the youngest wins for both stall and forward.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined, adds outputs stall_cnt_o[31:0] and fwd_cnt_o[31:0]:
  - stall_cnt_o increments each cycle stall_o=1.
  - fwd_cnt_o increments each cycle any fwd_sel_o≠0.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Without it: no counters, ports absent, identical hazard behaviour.

Decomposition:
- Shared package haz_pkg:
  - FWD_RF=0 constant.
  - Scoreboard entry typedef {valid, rd, is_load}.
  - ready_stage function (is_load, LOAD_LAT).
- Sub-module haz_match: one source address vs. all entries → youngest matching age + hit. Instantiated NUM_SRC times for ID and NUM_SRC times for EX.

Test Plan:
1. ALU→ALU: add r3 then sub r4,r3,r5 (defaults) → no stall; next cycle fwd_sel src0=2, src1=0.
2. Load-use: lw r2 then add r6,r2,r7 → stall_o=1 one cycle, pc_write_o=0; after the bubble fwd_sel src0=3.
3. LOAD_LAT=2, DEPTH=4: lw r2; add uses r2 → two stall cycles, then fwd_sel=4.
4. Youngest wins: add r1; add r1; or r8,r1,r1 → fwd_sel src0=src1=2, not 3.
5. Zero register and unused operands: writes to r0 / unused source matching a load rd → stall_o=0, fwd_sel=0.
6. Flush during load-use stall: lw r2; dependent in ID with flush_i=1 → stall_o=0, bubble issued, next cycle fwd_sel=0.
7. Reset: rst_n_i low mid-stall → stall_o=0, all selects 0 immediately.

Source files
------------

// File: rtl/haz_pkg.sv
// Shared types and helpers for the hazard/forwarding unit: scoreboard entry
// layout, register-file select code and per-producer ready stage.
package haz_pkg;

  localparam int FWD_RF = 0;

  // Widest register address the scoreboard entry can hold.
  localparam int SB_RD_W = 8;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               is_load;
  } sb_entry_t;

  // Age at which a producer's result becomes forwardable.
  function automatic int unsigned ready_stage(input logic is_load, input int unsigned load_lat);
    return is_load ? 32'd2 + load_lat : 32'd2;
  endfunction

endpackage

// File: rtl/haz_match.sv
// Compares one source register against scoreboard ages MIN_AGE..DEPTH and
// reports the youngest valid matching producer.
module haz_match
  import haz_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int DEPTH   = 3,
  parameter int MIN_AGE = 1,
  parameter int SEL_W   = 2
) (
  input  logic                  src_used,
  input  logic [REG_AW-1:0]     src,
  input  sb_entry_t [DEPTH:1]   sb,
  output logic                  hit,
  output logic [SEL_W-1:0]      age,
  output logic                  is_load
);

  // Scan oldest to youngest so the youngest writer overrides older ones.
  always_comb begin
    hit     = 1'b0;
    age     = '0;
    is_load = 1'b0;
    for (int a = DEPTH; a >= MIN_AGE; a--) begin
      if (src_used && (src != '0) && sb[a].valid && (sb[a].rd == SB_RD_W'(src))) begin
        hit     = 1'b1;
        age     = SEL_W'(a);
        is_load = sb[a].is_load;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Scoreboard-based forwarding and load-use hazard unit for a parametrised pipeline.
// Optional performance counters are enabled with `define HAZ_PERF_CNT_EN.
module hazard_fwd_unit
  import haz_pkg::*;
#(
  parameter int          REG_AW   = 5,
  parameter int          NUM_SRC  = 2,
  parameter int          DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int          SEL_W    = $clog2(DEPTH+1)
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src_i,
  input  logic [NUM_SRC-1:0]          id_src_used_i,
  input  logic [REG_AW-1:0]           id_rd_i,
  input  logic                        id_regwrite_i,
  input  logic                        id_memread_i,
  input  logic                        flush_i,
  output logic                        stall_o,
  output logic                        pc_write_o,
  output logic                        if_id_write_o,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]                 stall_cnt_o,
  output logic [31:0]                 fwd_cnt_o
`endif
);

  sb_entry_t [DEPTH:1]              sb;
  logic [NUM_SRC-1:0][REG_AW-1:0]   ex_src;
  logic [NUM_SRC-1:0]               ex_used;

  logic [NUM_SRC-1:0]               id_hit, id_load, id_haz;
  logic [NUM_SRC-1:0][SEL_W-1:0]    id_age;
  logic [NUM_SRC-1:0]               ex_hit, ex_load;
  logic [NUM_SRC-1:0][SEL_W-1:0]    ex_age;
  logic [NUM_SRC-1:0][SEL_W-1:0]    fwd_sel;
  logic                             issue;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    haz_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .MIN_AGE(1), .SEL_W(SEL_W)) u_id_match (
      .src_used (id_src_used_i[s]),
      .src      (id_src_i[s*REG_AW +: REG_AW]),
      .sb       (sb),
      .hit      (id_hit[s]),
      .age      (id_age[s]),
      .is_load  (id_load[s])
    );

    // Age 1 is the EX instruction itself, so forwarding looks from age 2.
    haz_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .MIN_AGE(2), .SEL_W(SEL_W)) u_ex_match (
      .src_used (ex_used[s]),
      .src      (ex_src[s]),
      .sb       (sb),
      .hit      (ex_hit[s]),
      .age      (ex_age[s]),
      .is_load  (ex_load[s])
    );

    // The producer will be one stage older when this instruction reaches EX.
    assign id_haz[s]  = id_hit[s] &&
                        ((32'(id_age[s]) + 32'd1) < ready_stage(id_load[s], LOAD_LAT));
    assign fwd_sel[s] = (ex_hit[s] && (32'(ex_age[s]) >= ready_stage(ex_load[s], LOAD_LAT)))
                        ? ex_age[s] : SEL_W'(FWD_RF);

`ifndef SYNTHESIS
    a_fwd_ready: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !(ex_hit[s] && (32'(ex_age[s]) < ready_stage(ex_load[s], LOAD_LAT))));
`endif
  end

  assign stall_o       = id_valid_i && !flush_i && (|id_haz);
  assign pc_write_o    = !stall_o;
  assign if_id_write_o = !stall_o;
  assign fwd_sel_o     = fwd_sel;
  assign issue         = id_valid_i && !stall_o && !flush_i;

  // ID -> EX issue and scoreboard ageing
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sb      <= '0;
      ex_src  <= '0;
      ex_used <= '0;
    end else begin
      for (int a = DEPTH; a >= 2; a--) begin
        sb[a] <= sb[a-1];
      end
      sb[1].valid   <= issue && id_regwrite_i && (id_rd_i != '0);
      sb[1].rd      <= SB_RD_W'(id_rd_i);
      sb[1].is_load <= issue && id_memread_i;
      ex_src        <= id_src_i;
      ex_used       <= issue ? id_src_used_i : '0;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
      fwd_cnt_o   <= '0;
    end else begin
      if (stall_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 32'd1;
      if ((|fwd_sel) && (fwd_cnt_o != '1)) fwd_cnt_o <= fwd_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: vector tables, a reset-mid-stall sequence and
// randomized traffic against a per-register last-writer model.
module tb_hazard_fwd_unit;

  localparam int AW = 5;
  localparam int NS = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            id_valid = 1'b0;
  logic [NS*AW-1:0] id_src = '0;
  logic [NS-1:0]   id_used = '0;
  logic [AW-1:0]   id_rd = '0;
  logic            id_rw = 1'b0;
  logic            id_mr = 1'b0;
  logic            flush = 1'b0;

  logic            stall_a, pcw_a, ifid_a;
  logic [3:0]      fwd_a;
  logic            stall_b, pcw_b, ifid_b;
  logic [5:0]      fwd_b;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]     scnt_a, fcnt_a, scnt_b, fcnt_b;
`endif

  always #5 clk = ~clk;

  hazard_fwd_unit dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid), .id_src_i(id_src),
    .id_src_used_i(id_used), .id_rd_i(id_rd), .id_regwrite_i(id_rw),
    .id_memread_i(id_mr), .flush_i(flush), .stall_o(stall_a),
    .pc_write_o(pcw_a), .if_id_write_o(ifid_a), .fwd_sel_o(fwd_a)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt_o(scnt_a), .fwd_cnt_o(fcnt_a)
`endif
  );

  hazard_fwd_unit #(.DEPTH(4), .LOAD_LAT(2)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid), .id_src_i(id_src),
    .id_src_used_i(id_used), .id_rd_i(id_rd), .id_regwrite_i(id_rw),
    .id_memread_i(id_mr), .flush_i(flush), .stall_o(stall_b),
    .pc_write_o(pcw_b), .if_id_write_o(ifid_b), .fwd_sel_o(fwd_b)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt_o(scnt_b), .fwd_cnt_o(fcnt_b)
`endif
  );

  typedef struct {
    bit       v;
    int       s0, s1;
    bit [1:0] u;
    int       rd;
    bit       rw, mr, fl;
    bit       stall;
    int       f0, f1;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic vec_t mk(bit v, int s0, int s1, bit [1:0] u, int rd, bit rw, bit mr,
                              bit fl, bit st, int f0, int f1);
    vec_t r;
    r.v = v; r.s0 = s0; r.s1 = s1; r.u = u; r.rd = rd; r.rw = rw; r.mr = mr;
    r.fl = fl; r.stall = st; r.f0 = f0; r.f1 = f1;
    return r;
  endfunction

  function automatic int got_stall(int k);
    return (k == 0) ? int'(stall_a) : int'(stall_b);
  endfunction
  function automatic int got_pcw(int k);
    return (k == 0) ? int'(pcw_a) : int'(pcw_b);
  endfunction
  function automatic int got_ifid(int k);
    return (k == 0) ? int'(ifid_a) : int'(ifid_b);
  endfunction
  function automatic int got_fwd(int k, int s);
    if (k == 0) return int'(fwd_a[s*2 +: 2]);
    return int'(fwd_b[s*3 +: 3]);
  endfunction

  task automatic apply(input vec_t r);
    id_valid = r.v;
    id_src   = {AW'(r.s1), AW'(r.s0)};
    id_used  = r.u;
    id_rd    = AW'(r.rd);
    id_rw    = r.rw;
    id_mr    = r.mr;
    flush    = r.fl;
  endtask

  task automatic idle();
    apply(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Reference model: for every register, the cycle its most recent writer
  // entered EX; age follows from the cycle count.
  int  cyc;
  int  last_t [2][32];
  bit  last_v [2][32];
  bit  last_ld[2][32];
  int  exp_f  [2][2];
  int  nxt_f  [2][2];
  int  stall_seen, fwd_seen;

  function automatic int depth_of(int k);
    return (k == 0) ? 3 : 4;
  endfunction
  function automatic int ready_of(int k, bit ld);
    return ld ? (2 + ((k == 0) ? 1 : 2)) : 2;
  endfunction
  function automatic int src_of(int s);
    return int'(id_src[s*AW +: AW]);
  endfunction
  function automatic int wage(int k, int r);
    int a;
    if (r == 0 || !last_v[k][r]) return 0;
    a = cyc - last_t[k][r] + 1;
    return (a <= depth_of(k)) ? a : 0;
  endfunction
  function automatic bit m_stall(int k);
    if (!id_valid || flush) return 1'b0;
    for (int s = 0; s < NS; s++) begin
      int r, a;
      r = src_of(s);
      a = wage(k, r);
      if (id_used[s] && a != 0 && (a + 1) < ready_of(k, last_ld[k][r])) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    cyc = 0;
    stall_seen = 0;
    fwd_seen = 0;
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) begin
        last_v[k][r] = 1'b0; last_t[k][r] = 0; last_ld[k][r] = 1'b0;
      end
      for (int s = 0; s < NS; s++) exp_f[k][s] = 0;
    end
  endtask

  task automatic reset_all(input string tag);
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.k%0d.stall", tag, k), got_stall(k), 0);
      chk($sformatf("%s.k%0d.pc_write", tag, k), got_pcw(k), 1);
      chk($sformatf("%s.k%0d.fwd", tag, k), got_fwd(k, 0) + got_fwd(k, 1), 0);
    end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string tag, input int k, input vec_t tbl[$]);
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("%s%0d.stall", tag, i), got_stall(k), int'(tbl[i].stall));
      chk($sformatf("%s%0d.pc_write", tag, i), got_pcw(k), int'(!tbl[i].stall));
      chk($sformatf("%s%0d.if_id_write", tag, i), got_ifid(k), int'(!tbl[i].stall));
      chk($sformatf("%s%0d.fwd0", tag, i), got_fwd(k, 0), tbl[i].f0);
      chk($sformatf("%s%0d.fwd1", tag, i), got_fwd(k, 1), tbl[i].f1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_cycle(input int n);
    bit st[2];
    id_valid = ($urandom_range(0, 99) < 85);
    flush    = ($urandom_range(0, 99) < 10);
    id_src   = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
    id_used  = NS'($urandom_range(0, 3));
    id_rd    = AW'($urandom_range(0, 3));
    id_rw    = ($urandom_range(0, 99) < 75);
    id_mr    = ($urandom_range(0, 99) < 30);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      st[k] = m_stall(k);
      chk($sformatf("R%0d.k%0d.stall", n, k), got_stall(k), int'(st[k]));
      for (int s = 0; s < NS; s++) begin
        int r, a;
        chk($sformatf("R%0d.k%0d.fwd%0d", n, k, s), got_fwd(k, s), exp_f[k][s]);
        r = src_of(s);
        a = wage(k, r);
        nxt_f[k][s] = (id_valid && !flush && !st[k] && id_used[s] && a != 0 &&
                       (a + 1) <= depth_of(k)) ? a + 1 : 0;
      end
    end
    if (st[0]) stall_seen++;
    if (exp_f[0][0] != 0 || exp_f[0][1] != 0) fwd_seen++;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (id_valid && !flush && !st[k] && id_rw && id_rd != '0) begin
        last_t[k][int'(id_rd)]  = cyc;
        last_v[k][int'(id_rd)]  = 1'b1;
        last_ld[k][int'(id_rd)] = id_mr;
      end
      for (int s = 0; s < NS; s++) exp_f[k][s] = nxt_f[k][s];
    end
    #1;
  endtask

  initial begin
    vec_t ta[$];
    vec_t tb[$];

    // Default configuration: ALU chain, load-use, youngest-wins, r0/unused, flush.
    ta.push_back(mk(1, 1, 2, 2'b11, 3, 1, 0, 0, 0, 0, 0));
    ta.push_back(mk(1, 3, 5, 2'b11, 4, 1, 0, 0, 0, 0, 0));
    ta.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2, 0));
    ta.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    ta.push_back(mk(1, 9, 0, 2'b01, 2, 1, 1, 0, 0, 0, 0));
    ta.push_back(mk(1, 2, 7, 2'b11, 6, 1, 0, 0, 1, 0, 0));
    ta.push_back(mk(1, 2, 7, 2'b11, 6, 1, 0, 0, 0, 0, 0));
    ta.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3, 0));
    ta.push_back(mk(1, 2, 3, 2'b11, 1, 1, 0, 0, 0, 0, 0));
    ta.push_back(mk(1, 4, 5, 2'b11, 1, 1, 0, 0, 0, 0, 0));
    ta.push_back(mk(1, 1, 1, 2'b11, 8, 1, 0, 0, 0, 0, 0));
    ta.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2, 2));
    ta.push_back(mk(1, 9, 0, 2'b01, 0, 1, 1, 0, 0, 0, 0));
    ta.push_back(mk(1, 0, 0, 2'b11, 10, 1, 0, 0, 0, 0, 0));
    ta.push_back(mk(1, 9, 0, 2'b01, 11, 1, 1, 0, 0, 0, 0));
    ta.push_back(mk(1, 11, 11, 2'b00, 12, 1, 0, 0, 0, 0, 0));
    ta.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    ta.push_back(mk(1, 9, 0, 2'b01, 2, 1, 1, 0, 0, 0, 0));
    ta.push_back(mk(1, 2, 7, 2'b11, 6, 1, 0, 1, 0, 0, 0));
    ta.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));

    // DEPTH=4, LOAD_LAT=2: two load-use bubbles, then youngest ALU writer wins.
    tb.push_back(mk(1, 9, 0, 2'b01, 2, 1, 1, 0, 0, 0, 0));
    tb.push_back(mk(1, 2, 7, 2'b11, 6, 1, 0, 0, 1, 0, 0));
    tb.push_back(mk(1, 2, 7, 2'b11, 6, 1, 0, 0, 1, 0, 0));
    tb.push_back(mk(1, 2, 7, 2'b11, 6, 1, 0, 0, 0, 0, 0));
    tb.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 4, 0));
    tb.push_back(mk(1, 9, 0, 2'b01, 3, 1, 1, 0, 0, 0, 0));
    tb.push_back(mk(1, 9, 9, 2'b11, 3, 1, 0, 0, 0, 0, 0));
    tb.push_back(mk(1, 3, 3, 2'b11, 8, 1, 0, 0, 0, 0, 0));
    tb.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2, 2));

    model_reset();
    #2;
    reset_all("rst0");
    run_table("A", 0, ta);
    reset_all("rst1");
    run_table("B", 1, tb);
    reset_all("rst2");

    // Asynchronous reset while a load-use stall and a forward are both active.
    apply(mk(1, 1, 2, 2'b11, 3, 1, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    apply(mk(1, 3, 0, 2'b01, 2, 1, 1, 0, 0, 0, 0));
    @(posedge clk); #1;
    apply(mk(1, 2, 7, 2'b11, 6, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("midrst.pre.stall_a", int'(stall_a), 1);
    chk("midrst.pre.pc_write_a", int'(pcw_a), 0);
    chk("midrst.pre.fwd0_a", got_fwd(0, 0), 2);
    chk("midrst.pre.stall_b", int'(stall_b), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.stall_a", int'(stall_a), 0);
    chk("midrst.pc_write_a", int'(pcw_a), 1);
    chk("midrst.if_id_write_a", int'(ifid_a), 1);
    chk("midrst.fwd_a", int'(fwd_a), 0);
    chk("midrst.stall_b", int'(stall_b), 0);
    chk("midrst.fwd_b", int'(fwd_b), 0);
    reset_all("rst3");

    for (int n = 0; n < 3000; n++) rand_cycle(n);
`ifdef HAZ_PERF_CNT_EN
    @(negedge clk);
    chk("perf.stall_cnt", int'(scnt_a), stall_seen);
    chk("perf.fwd_cnt", int'(fcnt_a), fwd_seen);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
